// File: rtl/vreg_port_arbiter.sv
// rtl/vreg_port_arbiter.sv - two-requester vector register file port arbiter; VREG_ARB_FIXED_PRIO_EN selects fixed A priority
module vreg_port_arbiter #(
    parameter int NELEM = 16,
    parameter int AW    = 3
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Req_a,
    input  logic                     Wr_a,
    input  logic                     Ser_a,
    input  logic [AW-1:0]            Addr_a,
    input  logic                     Req_b,
    input  logic                     Wr_b,
    input  logic                     Ser_b,
    input  logic [AW-1:0]            Addr_b,
    output logic                     Grant_a,
    output logic                     Grant_b,
    output logic                     Done_a,
    output logic                     Done_b,
    output logic                     Busy,
    output logic [AW-1:0]            Addr,
    output logic                     RD_p,
    output logic                     WR_p,
    output logic                     RD_s,
    output logic                     WR_s,
    output logic [$clog2(NELEM)-1:0] ElemIdx
);

    localparam int IW = $clog2(NELEM);
    localparam logic [IW-1:0] LAST   = IW'(NELEM - 1);
    localparam logic [IW-1:0] PENULT = IW'(NELEM - 2);

    typedef enum logic [1:0] {IDLE, PAR, SER, GAP} state_t;

    state_t        state;
    logic          op_b;
    logic          win_b;
    logic          sel_wr;
    logic          sel_ser;
    logic [AW-1:0] sel_addr;

`ifdef VREG_ARB_FIXED_PRIO_EN
    always_comb win_b = Req_b && !Req_a;
`else
    // prio_b = 1 means B wins the next tie
    logic prio_b;
    always_comb win_b = Req_b && (!Req_a || prio_b);
`endif

    always_comb begin
        sel_wr   = win_b ? Wr_b   : Wr_a;
        sel_ser  = win_b ? Ser_b  : Ser_a;
        sel_addr = win_b ? Addr_b : Addr_a;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= IDLE;
            op_b    <= 1'b0;
            Grant_a <= 1'b0;
            Grant_b <= 1'b0;
            Done_a  <= 1'b0;
            Done_b  <= 1'b0;
            Busy    <= 1'b0;
            Addr    <= '0;
            RD_p    <= 1'b0;
            WR_p    <= 1'b0;
            RD_s    <= 1'b0;
            WR_s    <= 1'b0;
            ElemIdx <= '0;
`ifndef VREG_ARB_FIXED_PRIO_EN
            prio_b  <= 1'b0;
`endif
        end else begin
            Grant_a <= 1'b0;
            Grant_b <= 1'b0;
            Done_a  <= 1'b0;
            Done_b  <= 1'b0;
            case (state)
                IDLE: begin
                    RD_p    <= 1'b0;
                    WR_p    <= 1'b0;
                    RD_s    <= 1'b0;
                    WR_s    <= 1'b0;
                    ElemIdx <= '0;
                    Busy    <= 1'b0;
                    if (Req_a || Req_b) begin
                        op_b    <= win_b;
                        Addr    <= sel_addr;
                        Busy    <= 1'b1;
                        Grant_a <= !win_b;
                        Grant_b <= win_b;
                        if (sel_ser) begin
                            state <= SER;
                            WR_s  <= sel_wr;
                            RD_s  <= !sel_wr;
                        end else begin
                            state  <= PAR;
                            WR_p   <= sel_wr;
                            RD_p   <= !sel_wr;
                            Done_a <= !win_b;
                            Done_b <= win_b;
                        end
`ifndef VREG_ARB_FIXED_PRIO_EN
                        if (Req_a && Req_b) prio_b <= !win_b;
`endif
                    end
                end
                PAR: begin
                    state <= GAP;
                    RD_p  <= 1'b0;
                    WR_p  <= 1'b0;
                end
                SER: begin
                    // leaving via the state change keeps the strobe low for a cycle so the RF sees a fresh edge
                    if (ElemIdx == LAST) begin
                        state   <= GAP;
                        RD_s    <= 1'b0;
                        WR_s    <= 1'b0;
                        ElemIdx <= '0;
                    end else begin
                        ElemIdx <= ElemIdx + IW'(1);
                        if (ElemIdx == PENULT) begin
                            Done_a <= !op_b;
                            Done_b <= op_b;
                        end
                    end
                end
                GAP: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/vreg_port_arbiter.md
Name: vreg_port_arbiter

Overview:
- Shares the 8x16x16-bit vector register file between two requesters: A (load/store unit) and B (vector ALU).
- Each request is either a parallel transfer (one 256-bit beat) or a serial transfer (NELEM 16-bit elements).
- Drives the register file's Addr, RD_p, WR_p, RD_s and WR_s strobes, and supplies an element index for serial data steering.
- Inserts a mandatory idle cycle between operations. The register file restarts its element counter only on a rising edge of RD_s/WR_s, so back-to-back serial strobes would not restart it.

Parameters:
- NELEM, 16, elements per vector (serial beats); power of 2, 2..16.
- AW, 3, register address width.

Ports:
- Clk  in  1  single system clock; all state updates on rising edge.
- Rst_n  in  1  synchronous active-low reset, sampled on rising Clk.
- Req_a  in  1  requester A request; hold high until Done_a.
- Wr_a  in  1  A direction: 1 = write, 0 = read.
- Ser_a  in  1  A mode: 1 = serial, 0 = parallel.
- Addr_a  in  AW  A target register.
- Req_b, Wr_b, Ser_b, Addr_b  in  1,1,1,AW  same fields for requester B.
- Grant_a, Grant_b  out  1  one-cycle pulse in the first cycle of the granted operation.
- Done_a, Done_b  out  1  one-cycle pulse in the last strobe cycle of the operation.
- Busy  out  1  high in any state other than IDLE.
- Addr  out  AW  register address to the register file.
- RD_p, WR_p, RD_s, WR_s  out  1  register file strobes.
- ElemIdx  out  log2(NELEM)  current serial element; 0 when not in SER.

Behaviour:
- Reset (Rst_n low at a rising edge) takes effect immediately, including mid-operation; the aborted operation gets no Done.
  - State goes to IDLE.
  - All outputs go to 0: Grant, Done, Busy, Addr, strobes, ElemIdx.
  - Round-robin pointer goes to "A preferred".
- States: IDLE, PAR, SER, GAP. All outputs are registered.
- IDLE: Req_a and Req_b are sampled.
  - Only one requester high: that requester wins.
  - Both high: the preferred requester wins, then the pointer flips to the other requester.
  - On a win, the winner's Addr, Wr and Ser are latched. Next state is PAR if Ser=0, otherwise SER.
  - Latency from Req high in IDLE to first strobe is 1 cycle.
- PAR, 1 cycle:
  - Asserts WR_p if Wr=1, otherwise RD_p.
  - Grant_x and Done_x both pulse this cycle.
  - Next state is GAP.
- SER, exactly NELEM cycles:
  - Asserts WR_s or RD_s continuously.
  - ElemIdx counts 0..NELEM-1, one per cycle.
  - Grant_x pulses on ElemIdx=0; Done_x pulses on ElemIdx=NELEM-1.
  - Next state is GAP.
- GAP, 1 cycle:
  - All strobes are 0; Addr holds its last value; Busy stays 1.
  - Next state is IDLE. Requests are not sampled in GAP.
- Addr is stable from the first strobe cycle through GAP, and changes only when leaving IDLE.
- Input changes are ignored during an operation:
  - Dropping Req_x mid-operation does not abort it.
  - Changing Addr_x, Wr_x or Ser_x mid-operation has no effect.
- Exactly one strobe is high in PAR/SER; none is high in IDLE or GAP.
- Minimum spacing between operation starts:
  - Parallel: 3 cycles (PAR, GAP, IDLE).
  - Serial: NELEM+2 cycles.
- A requester held high continuously is served again after the other one, never twice in a row while the other is waiting.
- ElemIdx wraps only via the state change, not by counter overflow.

Optional Feature:
- Macro VREG_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. A always wins when both requesters are high, and the round-robin pointer is removed.
- Undefined (default): round robin as described in Behaviour.

Test Plan:
- Reset, then Req_a=1, Ser_a=0, Wr_a=1, Addr_a=3 → next cycle: WR_p=1, Addr=3, Grant_a=1, Done_a=1. Following cycle: GAP, all strobes 0, Busy=1. Cycle after: Busy=0.
- Req_b=1, Ser_b=1, Wr_b=0, Addr_b=5 → RD_s high for exactly 16 cycles, ElemIdx 0..15, Grant_b on idx 0, Done_b on idx 15. Then one cycle with RD_s=0 before IDLE.
- Req_a and Req_b both held high with serial writes to registers 1 and 2 → grant order A, B, A, B. Each WR_s burst is separated by exactly 2 strobe-low cycles.
  - With VREG_ARB_FIXED_PRIO_EN defined, the order is A, A, A.
- During an A serial write, raise Req_b with Addr_b=7 and change Addr_a to 6 → Addr stays at the original A value for all 16 beats. B is granted only after GAP.
- Rst_n=0 at ElemIdx=8 of a serial write → next cycle: all outputs 0, state IDLE, no Done_a. A pending Req_b is granted 1 cycle after Rst_n returns high.
